// File: rtl/seq_replayer_pkg.sv
// Shared types and helpers for the tick-paced address sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_replayer_pkg;

  // Run mode codes; the reserved code is executed as a one-shot.
  typedef enum logic [1:0] {
    MODE_ONCE     = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Enabled clock cycles per address step, never below one.
  function automatic int clamp_div(input int clk_hz, input int tick_hz);
    int d;
    d = clk_hz / tick_hz;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/seq_replayer_tick_prescaler.sv
// Purpose: divide enabled cycles by DIV and flag the last one of each group as a tick.
// Latency: tick is combinational from the counter and en, asserted in the DIV-th enabled cycle after clr.
// Backpressure: en=0 freezes the counter; clr returns it to zero and takes priority over en.
// Ports: clk, rst (sync, active high), clr (restart phase), en (count this cycle), tick (out).
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_replayer.sv
// Purpose: step a memory address from base toward limit once per tick (once / loop / ping-pong, either direction).
// Latency: start presents base at the next edge; each later address appears one edge after its tick.
// Backpressure: count=0 pauses the prescaler and address; stop aborts with addr held and no done.
// Ports: clk, rst (sync, active high), start, stop, count, base, limit, mode
//        -> addr (registered), next (new-addr pulse), busy (in RUN), done (one-shot completion pulse).
module seq_replayer
  import seq_replayer_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 12_000_000,
  parameter int TICK_PER_SEC  = 1000,
  parameter int ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              count,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic              next,
  output logic              busy,
  output logic              done
);

  localparam int DIV = clamp_div(CLOCK_FREQ_HZ, TICK_PER_SEC);

  state_t            state, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic [ADDR_W-1:0] addr_d;
  logic              dir_up, dir_d;
  logic              next_d, busy_d, done_d;
  logic              tick;
  logic              toward_lim;

  // One step toward target, saturating on it: the address can never wrap
  // past either endpoint regardless of direction.
  function automatic logic [ADDR_W-1:0] step_toward(input logic [ADDR_W-1:0] a,
                                                     input logic [ADDR_W-1:0] t);
    if (a < t)      return a + ADDR_W'(1);
    else if (a > t) return a - ADDR_W'(1);
    else            return a;
  endfunction

  // Start (and stop) restart the step phase so a fresh run always holds
  // each address for a full DIV enabled cycles.
  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (start || stop),
    .en   ((state == ST_RUN) && count),
    .tick (tick)
  );

  // dir_up is the absolute direction; the run is on its outbound leg while
  // the direction matches the base->limit orientation.
  assign toward_lim = (dir_up == (limit_q >= base_q));

  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    base_d  = base_q;
    limit_d = limit_q;
    addr_d  = addr;
    dir_d   = dir_up;
    next_d  = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;

    if (start) begin
      state_d = ST_RUN;
      mode_d  = mode_t'(mode);
      base_d  = base;
      limit_d = limit;
      addr_d  = base;
      dir_d   = (limit >= base);
      next_d  = 1'b1;
      busy_d  = 1'b1;
    end else if (state == ST_RUN) begin
      if (stop) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else if (tick) begin
        if (toward_lim) begin
          if (addr != limit_q) begin
            addr_d = step_toward(addr, limit_q);
            next_d = 1'b1;
          end else begin
            unique case (mode_q)
              MODE_LOOP: begin
                addr_d = base_q;
                next_d = 1'b1;
              end
              MODE_PINGPONG: begin
                dir_d  = ~dir_up;
                addr_d = step_toward(addr, base_q);
                next_d = 1'b1;
              end
              default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end else begin
          // Only ping-pong runs ever travel back toward base.
          if (addr != base_q) begin
            addr_d = step_toward(addr, base_q);
          end else begin
            dir_d  = ~dir_up;
            addr_d = step_toward(addr, limit_q);
          end
          next_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_ONCE;
      base_q  <= '0;
      limit_q <= '0;
      addr    <= '0;
      dir_up  <= 1'b1;
      next    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      limit_q <= limit_d;
      addr    <= addr_d;
      dir_up  <= dir_d;
      next    <= next_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_replayer.sv
// Purpose: directed checks of seq_replayer at DIV=1, 2 and 4 with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: count/stop/start/rst driven directly by the stimulus sequence.
module tb_seq_replayer;

  logic       clk = 1'b0;
  logic       rst, start, stop, count;
  logic [7:0] base, limit;
  logic [1:0] mode;

  logic [7:0] a1, a2, a4;
  logic       n1, b1, d1, n2, b2, d2, n4, b4, d4;

  int vec_cnt  = 0;
  int miscmp   = 0;

  always #5 clk = ~clk;

  // DIV = max(1, 1/3) = 1
  seq_replayer #(.CLOCK_FREQ_HZ(1), .TICK_PER_SEC(3), .ADDR_W(8)) u_div1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .count(count),
    .base(base), .limit(limit), .mode(mode),
    .addr(a1), .next(n1), .busy(b1), .done(d1));

  // DIV = 2/1 = 2
  seq_replayer #(.CLOCK_FREQ_HZ(2), .TICK_PER_SEC(1), .ADDR_W(8)) u_div2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .count(count),
    .base(base), .limit(limit), .mode(mode),
    .addr(a2), .next(n2), .busy(b2), .done(d2));

  // DIV = 8/2 = 4
  seq_replayer #(.CLOCK_FREQ_HZ(8), .TICK_PER_SEC(2), .ADDR_W(8)) u_div4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .count(count),
    .base(base), .limit(limit), .mode(mode),
    .addr(a4), .next(n4), .busy(b4), .done(d4));

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      miscmp++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns sampled just after the start edge.
  task automatic go(input logic [7:0] b, input logic [7:0] l, input logic [1:0] m);
    base  = b;
    limit = l;
    mode  = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int npulse, ndone, done_c;
    int pp_seq[9] = '{3, 4, 5, 6, 5, 4, 3, 4, 5};

    rst = 1'b1; start = 1'b0; stop = 1'b0; count = 1'b1;
    base = '0; limit = '0; mode = '0;
    cyc(); cyc();
    check("rst_addr", int'(a1), 0);
    check("rst_next", int'(n1), 0);
    check("rst_busy", int'(b1), 0);
    check("rst_done", int'(d1), 0);
    check("rst_addr4", int'(a4), 0);
    rst = 1'b0;
    cyc();

    // 1: DIV=1 ONCE 0..13
    go(8'd0, 8'd13, 2'd0);
    npulse = 0; ndone = 0; done_c = -1;
    for (int c = 0; c < 20; c++) begin
      if (n1) begin
        check("t1_addr_on_next", int'(a1), npulse);
        npulse++;
      end
      if (d1) begin
        ndone++;
        done_c = c;
      end
      cyc();
    end
    check("t1_next_count", npulse, 14);
    check("t1_done_count", ndone, 1);
    check("t1_done_cycle", done_c, 14);
    check("t1_busy_after", int'(b1), 0);
    check("t1_addr_after", int'(a1), 13);

    // 2: DIV=4 LOOP 2..5
    go(8'd2, 8'd5, 2'd1);
    for (int c = 0; c < 24; c++) begin
      check("t2_addr", int'(a4), 2 + ((c / 4) % 4));
      check("t2_next", int'(n4), (c % 4 == 0) ? 1 : 0);
      check("t2_done", int'(d4), 0);
      cyc();
    end

    // 3: DIV=1 PINGPONG 3..6
    go(8'd3, 8'd6, 2'd2);
    for (int c = 0; c < 9; c++) begin
      check("t3_addr", int'(a1), pp_seq[c]);
      check("t3_next", int'(n1), 1);
      cyc();
    end

    // 4: DIV=2 ONCE reverse 10..7
    go(8'd10, 8'd7, 2'd0);
    for (int c = 0; c < 10; c++) begin
      check("t4_addr", int'(a2), (c < 6) ? 10 - c / 2 : 7);
      check("t4_next", int'(n2), (c % 2 == 0 && c <= 6) ? 1 : 0);
      check("t4_done", int'(d2), (c == 8) ? 1 : 0);
      check("t4_busy", int'(b2), (c < 8) ? 1 : 0);
      cyc();
    end

    // 5: DIV=4 LOOP pause, stop on a tick cycle, start+stop restart
    go(8'd2, 8'd5, 2'd1);
    repeat (5) cyc();
    check("t5_pre_addr", int'(a4), 3);
    count = 1'b0;
    repeat (7) begin
      cyc();
      check("t5_pause_addr", int'(a4), 3);
      check("t5_pause_busy", int'(b4), 1);
      check("t5_pause_next", int'(n4), 0);
    end
    count = 1'b1;
    cyc(); cyc();
    check("t5_resume_hold", int'(a4), 3);
    cyc();
    check("t5_resume_addr", int'(a4), 4);
    check("t5_resume_next", int'(n4), 1);
    repeat (3) cyc();
    check("t5_pre_stop", int'(a4), 4);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("t5_stop_busy", int'(b4), 0);
    check("t5_stop_addr", int'(a4), 4);
    check("t5_stop_next", int'(n4), 0);
    check("t5_stop_done", int'(d4), 0);
    repeat (6) begin
      cyc();
      check("t5_idle_addr", int'(a4), 4);
      check("t5_idle_busy", int'(b4), 0);
      check("t5_idle_done", int'(d4), 0);
    end
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    check("t5_ss_addr", int'(a4), 2);
    check("t5_ss_next", int'(n4), 1);
    check("t5_ss_busy", int'(b4), 1);

    // 6: reset mid-run in PINGPONG, with start also asserted
    go(8'd3, 8'd6, 2'd2);
    repeat (4) cyc();
    check("t6_pre_addr", int'(a1), 5);
    rst   = 1'b1;
    start = 1'b1;
    cyc();
    rst   = 1'b0;
    start = 1'b0;
    check("t6_rst_addr", int'(a1), 0);
    check("t6_rst_busy", int'(b1), 0);
    check("t6_rst_next", int'(n1), 0);
    check("t6_rst_done", int'(d1), 0);
    cyc();
    check("t6_idle_busy", int'(b1), 0);
    check("t6_idle_addr", int'(a1), 0);
    go(8'd3, 8'd6, 2'd2);
    for (int c = 0; c < 5; c++) begin
      check("t6_again_addr", int'(a1), pp_seq[c]);
      check("t6_again_busy", int'(b1), 1);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
